// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_DEF         = 32;
    localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetchState_e;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: bubble beats load, neither means hold.
module ifid_pipe_reg
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pcNext,
    input  logic [XLEN-1:0] pcPlus4Next,
    input  logic [31:0]     instrNext,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic [31:0]     instr,
    output logic            valid
);

    // A bubble only clears the instruction and valid; pc fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            pcPlus4 <= '0;
            instr   <= NOP_INSTR;
            valid   <= 1'b0;
        end else if (bubble) begin
            instr   <= NOP_INSTR;
            valid   <= 1'b0;
        end else if (load) begin
            pc      <= pcNext;
            pcPlus4 <= pcPlus4Next;
            instr   <= instrNext;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, boot/run/halt control
// and the IF/ID register feeding decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [31:0]     NOP_INSTR    = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write_en_i,
    input  logic            ifid_en_i,
    input  logic            flush_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc_plus4_o,
    output logic [31:0]     id_instr_o,
    output logic            id_valid_o,
    output logic            misalign_o,
    output logic [31:0]     fetch_count_o
);

    fetchState_e     stateQ;
    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcPlus4;
    logic            loadIfid;
    logic            bubbleIfid;
    logic            misTrap;
    logic            misalignQ;
    logic [31:0]     fetchCountQ;

    // Next-PC and IF/ID control; only RUN reacts to the hazard and branch inputs.
    always_comb begin
        pcPlus4    = pcQ + XLEN'(4);
        pcD        = pcQ;
        loadIfid   = 1'b0;
        bubbleIfid = 1'b1;
        misTrap    = 1'b0;
        if (stateQ == RUN) begin
            bubbleIfid = flush_i | branch_taken_i;
            loadIfid   = ~bubbleIfid & ifid_en_i;
            if (branch_taken_i) begin
                if (branch_target_i[1:0] == 2'b00) begin
                    pcD = branch_target_i;
                end else begin
                    misTrap = 1'b1;
                end
            end else if (pc_write_en_i) begin
                pcD = pcPlus4;
            end
        end
    end

    // Memory sees the upcoming PC so its registered data lines up with pcQ.
    assign imem_addr_o = pcD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= BOOT;
            pcQ         <= RESET_VECTOR;
            misalignQ   <= 1'b0;
            fetchCountQ <= 32'd0;
        end else begin
            pcQ <= pcD;
            case (stateQ)
                BOOT:    stateQ <= RUN;
                RUN:     if (misTrap) stateQ <= HALT;
                HALT:    stateQ <= HALT;
                default: stateQ <= BOOT;
            endcase
            if (misTrap) begin
                misalignQ <= 1'b1;
            end
            if (loadIfid) begin
                fetchCountQ <= fetchCountQ + 32'd1;
            end
        end
    end

    assign misalign_o    = misalignQ;
    assign fetch_count_o = fetchCountQ;

    ifid_pipe_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (loadIfid),
        .bubble      (bubbleIfid),
        .pcNext      (pcQ),
        .pcPlus4Next (pcPlus4),
        .instrNext   (imem_rdata_i),
        .pc          (id_pc_o),
        .pcPlus4     (id_pc_plus4_o),
        .instr       (id_instr_o),
        .valid       (id_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_write_en_i;
    logic        ifid_en_i;
    logic        flush_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic [31:0] id_instr_o;
    logic        id_valid_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    int nChecks;
    int nErrors;

    // Model state: PC, IF/ID contents, flags
    logic [31:0] mPc;
    logic [31:0] mIdPc;
    logic [31:0] mIdPc4;
    logic [31:0] mIdInstr;
    logic        mIdValid;
    logic        mMis;
    logic [31:0] mCnt;
    bit          mBooted;
    bit          mHalted;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_write_en_i   (pc_write_en_i),
        .ifid_en_i       (ifid_en_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .id_pc_o         (id_pc_o),
        .id_pc_plus4_o   (id_pc_plus4_o),
        .id_instr_o      (id_instr_o),
        .id_valid_o      (id_valid_o),
        .misalign_o      (misalign_o),
        .fetch_count_o   (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Synchronous-read instruction memory with address-tagged contents
    always @(posedge clk) imem_rdata_i <= memWord(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkId();
        check("id_pc", id_pc_o, mIdPc);
        check("id_pc_plus4", id_pc_plus4_o, mIdPc4);
        check("id_instr", id_instr_o, mIdInstr);
        check("id_valid", 32'(id_valid_o), 32'(mIdValid));
        check("misalign", 32'(misalign_o), 32'(mMis));
        check("fetch_count", fetch_count_o, mCnt);
    endtask

    task automatic modelReset();
        mPc      = 32'h0;
        mIdPc    = 32'h0;
        mIdPc4   = 32'h0;
        mIdInstr = 32'h0;
        mIdValid = 1'b0;
        mMis     = 1'b0;
        mCnt     = 32'h0;
        mBooted  = 1'b0;
        mHalted  = 1'b0;
    endtask

    // Called at posedge+1; reset asserts between edges so outputs must clear asynchronously.
    task automatic doReset();
        rst_n           = 1'b0;
        pc_write_en_i   = 1'b0;
        ifid_en_i       = 1'b0;
        flush_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
        #1;
        modelReset();
        check("rst_imem_addr", imem_addr_o, 32'h0);
        checkId();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check the fetch address, then IF/ID after the edge.
    task automatic step(input bit pwe, input bit ifen, input bit fl, input bit br,
                        input logic [31:0] tgt);
        logic [31:0] nPc;
        pc_write_en_i   = pwe;
        ifid_en_i       = ifen;
        flush_i         = fl;
        branch_taken_i  = br;
        branch_target_i = tgt;
        #1;
        nPc = mPc;
        if (mBooted && !mHalted) begin
            if (br && tgt[1:0] == 2'b00) nPc = tgt;
            else if (br) begin
                mMis    = 1'b1;
                mHalted = 1'b1;
            end else if (pwe) nPc = mPc + 32'd4;
            if (fl || br) begin
                mIdInstr = 32'h0;
                mIdValid = 1'b0;
            end else if (ifen) begin
                mIdPc    = mPc;
                mIdPc4   = mPc + 32'd4;
                mIdInstr = memWord(mPc);
                mIdValid = 1'b1;
                mCnt     = mCnt + 32'd1;
            end
        end else begin
            mIdInstr = 32'h0;
            mIdValid = 1'b0;
        end
        check("imem_addr", imem_addr_o, nPc);
        @(posedge clk);
        #1;
        mPc     = nPc;
        mBooted = 1'b1;
        checkId();
    endtask

    initial begin
        int haltCycles;
        nChecks = 0;
        nErrors = 0;
        modelReset();
        rst_n           = 1'b1;
        pc_write_en_i   = 1'b0;
        ifid_en_i       = 1'b0;
        flush_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
        #1;
        doReset();

        // Boot then straight-line fetch to pc 0x10
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'h0);
        // Load-use stall at 0x10, then release
        step(0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0);
        // Branch to 0x40 from 0x20
        step(1, 1, 0, 1, 32'h40);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        // Flush wins over disabled IF/ID; stalled PC with enabled IF/ID reloads
        step(1, 0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        // Branch wins over held PC, then wrap past the top of memory
        step(0, 1, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 32'h0);
        // Misaligned target halts; later branches are ignored
        step(1, 1, 0, 1, 32'h42);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 1, 32'h80);
        step(1, 1, 1, 0, 32'h0);
        doReset();

        // Random phase with occasional resets
        haltCycles = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 19) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, t);
            if (mHalted) haltCycles++;
            if (haltCycles > 3 || $urandom_range(0, 199) == 0) begin
                haltCycles = 0;
                doReset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
